// File: rtl/chirp_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// chirp_sequencer_ctrl : radar chirp sequencer (init/ready/lead/chirp/tail/PRI)
// Optional watchdog: define CHIRP_SEQ_WATCHDOG_EN.      Revision: 1.0
// ============================================================================
module chirp_sequencer_ctrl #(
    parameter int READY_TIMEOUT = 4096,
    parameter int INDEX_WIDTH   = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic [INDEX_WIDTH-1:0] cfg_num_chirps,
    input  logic [31:0]            cfg_pri_cycles,
    input  logic [7:0]             cfg_adc_lead,
    input  logic [7:0]             cfg_adc_tail,
    input  logic                   chirp_ready,
    input  logic                   chirp_done,
    input  logic                   chirp_active,
    output logic                   chirp_init,
    output logic                   chirp_enable,
    output logic                   adc_enable,
    output logic                   busy,
    output logic                   seq_done,
    output logic [INDEX_WIDTH-1:0] chirp_index,
    output logic                   pri_overrun,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INIT       = 3'd1,
        S_WAIT_READY = 3'd2,
        S_ADC_LEAD   = 3'd3,
        S_CHIRP      = 3'd4,
        S_ADC_TAIL   = 3'd5,
        S_PRI_WAIT   = 3'd6,
        S_DONE       = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            pri_cnt_q, pri_cnt_d, pri_q, pri_d, pri_src;
    logic [7:0]             phase_q, phase_d, lead_q, lead_d, tail_q, tail_d;
    logic [INDEX_WIDTH-1:0] num_q, num_d, index_q, index_d, index_inc;
    logic [1:0]             inact_q, inact_d;
    logic                   overrun_q, overrun_d, timeout_q, timeout_d;
    logic                   init_q, init_d, cen_q, cen_d, aen_q, aen_d;
    logic                   busy_q, busy_d, sdone_q, sdone_d;
    logic                   last_after_chirp, last_after_tail;

`ifdef CHIRP_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(READY_TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    assign index_inc        = index_q + INDEX_WIDTH'(1);
    assign last_after_chirp = (num_q != '0) && (index_inc == num_q);
    assign last_after_tail  = (num_q != '0) && (index_q == num_q);
    assign pri_src          = (state_q == S_IDLE) ? cfg_pri_cycles : pri_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        index_d   = index_q;
        num_d     = num_q;
        pri_d     = pri_q;
        lead_d    = lead_q;
        tail_d    = tail_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        inact_d   = 2'd0;
        pri_cnt_d = (pri_cnt_q != 32'd0) ? pri_cnt_q - 32'd1 : 32'd0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop && cfg_pri_cycles != 32'd0) begin
                    state_d   = S_INIT;
                    num_d     = cfg_num_chirps;
                    pri_d     = cfg_pri_cycles;
                    lead_d    = cfg_adc_lead;
                    tail_d    = cfg_adc_tail;
                    index_d   = '0;
                    overrun_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_INIT: state_d = S_WAIT_READY;
            S_WAIT_READY: begin
                if (chirp_ready) begin
                    if (lead_q == 8'd0) begin
                        state_d = S_CHIRP;
                    end else begin
                        state_d = S_ADC_LEAD;
                        phase_d = lead_q - 8'd1;
                    end
                end
            end
            S_ADC_LEAD: begin
                if (phase_q == 8'd0) state_d = S_CHIRP;
                else                 phase_d = phase_q - 8'd1;
            end
            S_CHIRP: begin
                if (chirp_done) begin
                    index_d = index_inc;
                    if (tail_q == 8'd0) begin
                        state_d = last_after_chirp ? S_DONE : S_PRI_WAIT;
                    end else begin
                        state_d = S_ADC_TAIL;
                        phase_d = tail_q - 8'd1;
                    end
                end
            end
            S_ADC_TAIL: begin
                if (phase_q == 8'd0) state_d = last_after_tail ? S_DONE : S_PRI_WAIT;
                else                 phase_d = phase_q - 8'd1;
            end
            S_PRI_WAIT: if (pri_cnt_q == 32'd0) state_d = S_INIT;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

`ifdef CHIRP_SEQ_WATCHDOG_EN
        wd_d = '0;
        if ((state_q == S_WAIT_READY || state_q == S_CHIRP) && state_d == state_q) begin
            if (wd_q == WD_W'(READY_TIMEOUT - 1)) begin
                state_d   = S_DONE;
                timeout_d = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif

        // Abort wins over every other transition, including a same-cycle chirp_done.
        if (stop && state_q != S_IDLE && state_q != S_DONE) begin
            state_d = S_DONE;
            index_d = index_q;
        end

        if (state_d == S_INIT) pri_cnt_d = pri_src - 32'd1;
        if (state_d == S_PRI_WAIT && state_q != S_PRI_WAIT && pri_cnt_q == 32'd0)
            overrun_d = 1'b1;

        if (state_q == S_CHIRP && !chirp_active) begin
            if (inact_q == 2'd2) timeout_d = 1'b1;
            inact_d = (inact_q == 2'd2) ? 2'd2 : inact_q + 2'd1;
        end

        init_d  = (state_d == S_INIT);
        cen_d   = (state_d == S_CHIRP);
        aen_d   = (state_d == S_ADC_LEAD) || (state_d == S_CHIRP) || (state_d == S_ADC_TAIL);
        busy_d  = (state_d != S_IDLE);
        sdone_d = (state_d == S_DONE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            pri_cnt_q <= 32'd0;
            pri_q     <= 32'd0;
            phase_q   <= 8'd0;
            lead_q    <= 8'd0;
            tail_q    <= 8'd0;
            num_q     <= '0;
            index_q   <= '0;
            inact_q   <= 2'd0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            init_q    <= 1'b0;
            cen_q     <= 1'b0;
            aen_q     <= 1'b0;
            busy_q    <= 1'b0;
            sdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pri_cnt_q <= pri_cnt_d;
            pri_q     <= pri_d;
            phase_q   <= phase_d;
            lead_q    <= lead_d;
            tail_q    <= tail_d;
            num_q     <= num_d;
            index_q   <= index_d;
            inact_q   <= inact_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            init_q    <= init_d;
            cen_q     <= cen_d;
            aen_q     <= aen_d;
            busy_q    <= busy_d;
            sdone_q   <= sdone_d;
        end
    end

`ifdef CHIRP_SEQ_WATCHDOG_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) wd_q <= '0;
        else          wd_q <= wd_d;
    end
`endif

    assign chirp_init   = init_q;
    assign chirp_enable = cen_q;
    assign adc_enable   = aen_q;
    assign busy         = busy_q;
    assign seq_done     = sdone_q;
    assign chirp_index  = index_q;
    assign pri_overrun  = overrun_q;
    assign timeout_err  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_chirp_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_chirp_sequencer_ctrl : directed self-checking bench with a DDS responder
// Revision: 1.0
// ============================================================================
module tb_chirp_sequencer_ctrl;

`ifdef CHIRP_SEQ_WATCHDOG_EN
    localparam int DLY     = 10;
    localparam int OVR_PRI = 20;
`else
    localparam int DLY     = 100;
    localparam int OVR_PRI = 50;
`endif

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [15:0] cfg_num_chirps = 16'd0;
    logic [31:0] cfg_pri_cycles = 32'd0;
    logic [7:0]  cfg_adc_lead = 8'd0, cfg_adc_tail = 8'd0;
    logic        chirp_ready = 1'b0, chirp_done = 1'b0, chirp_active = 1'b0;
    logic        chirp_init, chirp_enable, adc_enable, busy, seq_done;
    logic [15:0] chirp_index;
    logic        pri_overrun, timeout_err;

    int tests = 0;
    int fails = 0;

    chirp_sequencer_ctrl #(.READY_TIMEOUT(16), .INDEX_WIDTH(16)) dut (
        .aclk(clk), .aresetn(aresetn), .start(start), .stop(stop),
        .cfg_num_chirps(cfg_num_chirps), .cfg_pri_cycles(cfg_pri_cycles),
        .cfg_adc_lead(cfg_adc_lead), .cfg_adc_tail(cfg_adc_tail),
        .chirp_ready(chirp_ready), .chirp_done(chirp_done), .chirp_active(chirp_active),
        .chirp_init(chirp_init), .chirp_enable(chirp_enable), .adc_enable(adc_enable),
        .busy(busy), .seq_done(seq_done), .chirp_index(chirp_index),
        .pri_overrun(pri_overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Event log and DDS responder, evaluated 2 ns after each rising edge.
    int   cyc = 0;
    int   init_q[$], done_q[$], adc_rise_q[$], adc_fall_q[$], ce_rise_q[$], ce_fall_q[$], cdone_q[$];
    bit   rdy_en = 1'b1, act_en = 1'b1;
    int   rdy_delay = 2, rcnt = 0, dcnt = 0;
    logic ce_prev = 1'b0, adc_prev = 1'b0;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (chirp_init) init_q.push_back(cyc);
        if (seq_done) done_q.push_back(cyc);
        if (adc_enable && !adc_prev) adc_rise_q.push_back(cyc);
        if (!adc_enable && adc_prev) adc_fall_q.push_back(cyc);
        if (chirp_enable && !ce_prev) ce_rise_q.push_back(cyc);
        if (!chirp_enable && ce_prev) ce_fall_q.push_back(cyc);
        if (!rdy_en) begin
            chirp_ready = 1'b0; rcnt = 0;
        end else if (chirp_init) begin
            chirp_ready = 1'b0; rcnt = rdy_delay;
        end else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) chirp_ready = 1'b1;
        end
        chirp_done = 1'b0;
        if (!chirp_enable) dcnt = 0;
        else if (!ce_prev) dcnt = DLY;
        else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                chirp_done = 1'b1;
                cdone_q.push_back(cyc);
            end
        end
        chirp_active = chirp_enable & act_en;
        ce_prev  = chirp_enable;
        adc_prev = adc_enable;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        init_q.delete(); done_q.delete(); adc_rise_q.delete(); adc_fall_q.delete();
        ce_rise_q.delete(); ce_fall_q.delete(); cdone_q.delete();
    endtask

    task automatic start_seq(input int n, input int pri, input int lead, input int tail);
        cfg_num_chirps = 16'(n);
        cfg_pri_cycles = 32'(pri);
        cfg_adc_lead   = 8'(lead);
        cfg_adc_tail   = 8'(tail);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_seq(input int budget, input string tag);
        int n0 = done_q.size();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_q.size() > n0) break;
        end
        check(tag, 32'(done_q.size() > n0), 32'd1);
        @(negedge clk);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_init", chirp_init, 0);
        check("rst_chirp_en", chirp_enable, 0);
        check("rst_adc_en", adc_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_index", chirp_index, 0);
        check("rst_overrun", pri_overrun, 0);
        check("rst_timeout", timeout_err, 0);
        aresetn = 1'b1;
        @(negedge clk);

        // Three chirps, PRI 200, lead 4, tail 8
        clear_logs();
        start_seq(3, 200, 4, 8);
        check("t1_init_pulse", chirp_init, 1);
        check("t1_busy", busy, 1);
        wait_seq(800, "t1_seq_done_seen");
        check("t1_init_count", init_q.size(), 3);
        if (init_q.size() == 3) begin
            check("t1_pri_gap1", init_q[1] - init_q[0], 200);
            check("t1_pri_gap2", init_q[2] - init_q[1], 200);
            check("t1_done_time", done_q[0] - init_q[0], 416 + DLY);
        end
        check("t1_lead", ce_rise_q[0] - adc_rise_q[0], 4);
        check("t1_ce_fall", ce_fall_q[0] - cdone_q[0], 1);
        check("t1_tail", adc_fall_q[0] - cdone_q[0], 9);
        check("t1_done_count", done_q.size(), 1);
        check("t1_index", chirp_index, 3);
        check("t1_overrun", pri_overrun, 0);
        check("t1_busy_end", busy, 0);

        // PRI shorter than the chirp
        clear_logs();
        start_seq(2, OVR_PRI, 4, 8);
        wait_seq(600, "t2_seq_done_seen");
        check("t2_overrun", pri_overrun, 1);
        check("t2_init_count", init_q.size(), 2);
        if (init_q.size() == 2) check("t2_init_after_pri_wait", init_q[1] - adc_fall_q[0], 1);
        check("t2_index", chirp_index, 2);

        // Continuous mode, abort during the 5th chirp
        clear_logs();
        start_seq(0, 150, 4, 8);
        check("t3_overrun_cleared", pri_overrun, 0);
        for (int i = 0; i < 1500; i++) begin
            if (ce_rise_q.size() >= 5) break;
            @(negedge clk);
        end
        check("t3_fifth_chirp", ce_rise_q.size(), 5);
        repeat (5) @(negedge clk);
        pulse_stop();
        check("t3_ce_low", chirp_enable, 0);
        check("t3_adc_low", adc_enable, 0);
        check("t3_seq_done", seq_done, 1);
        check("t3_index", chirp_index, 4);
        @(negedge clk);
        check("t3_busy_end", busy, 0);
        check("t3_seq_done_once", seq_done, 0);

        // Ignored starts
        clear_logs();
        stop = 1'b1;
        start_seq(1, 200, 4, 8);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_start_stop_busy", busy, 0);
        start_seq(1, 0, 4, 8);
        repeat (3) @(negedge clk);
        check("t4_pri0_busy", busy, 0);
        check("t4_no_init", init_q.size(), 0);
        start_seq(1, 200, 4, 8);
        repeat (20) @(negedge clk);
        start_seq(5, 300, 2, 2);
        repeat (3) @(negedge clk);
        check("t4_busy_kept", busy, 1);
        check("t4_busy_init_count", init_q.size(), 1);
        check("t4_still_chirping", chirp_enable, 1);
        wait_seq(400, "t4_seq_done_seen");
        check("t4_index", chirp_index, 1);
        check("t4_init_total", init_q.size(), 1);

        // Zero lead and tail
        clear_logs();
        start_seq(1, 200, 0, 0);
        wait_seq(400, "t5_seq_done_seen");
        check("t5_same_rise", ce_rise_q[0] - adc_rise_q[0], 0);
        check("t5_adc_fall", adc_fall_q[0] - cdone_q[0], 1);
        check("t5_ce_fall", ce_fall_q[0] - cdone_q[0], 1);

        // chirp_active stuck low during CHIRP
        act_en = 1'b0;
        clear_logs();
        start_seq(1, 200, 4, 8);
        wait_seq(400, "t6_seq_done_seen");
        check("t6_timeout", timeout_err, 1);
        check("t6_no_state_change", done_q[0] - init_q[0], 16 + DLY);
        act_en = 1'b1;

        // chirp_ready never arrives
        rdy_en = 1'b0;
        clear_logs();
        start_seq(1, 200, 4, 8);
        check("t7_timeout_cleared", timeout_err, 0);
`ifdef CHIRP_SEQ_WATCHDOG_EN
        wait_seq(100, "t7_wd_seq_done_seen");
        check("t7_wd_time", done_q[0] - init_q[0], 17);
        check("t7_wd_timeout", timeout_err, 1);
        check("t7_wd_no_adc", adc_rise_q.size(), 0);
`else
        repeat (60) @(negedge clk);
        check("t7_still_busy", busy, 1);
        check("t7_no_done", done_q.size(), 0);
        check("t7_no_adc", adc_enable, 0);
        pulse_stop();
        check("t7_stop_done", seq_done, 1);
        check("t7_no_timeout", timeout_err, 0);
        @(negedge clk);
`endif
        rdy_en = 1'b1;

        // Reset in the middle of a chirp
        clear_logs();
        start_seq(1, 200, 4, 8);
        repeat (20) @(negedge clk);
        check("t8_pre_chirping", chirp_enable, 1);
        aresetn = 1'b0;
        @(negedge clk);
        check("t8_ce_low", chirp_enable, 0);
        check("t8_adc_low", adc_enable, 0);
        check("t8_busy_low", busy, 0);
        check("t8_no_seq_done", seq_done, 0);
        aresetn = 1'b1;
        repeat (3) @(negedge clk);
        check("t8_done_count", done_q.size(), 0);
        check("t8_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
